instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the 8-bit tiny processor.
- Owns the PC and fetches opcodes from program memory over a req/ack handshake.
- Presents each fetched opcode to the combinational decode stage and gates its write enables with a one-cycle execute strobe.
- Provides run, single-step, HALT detection and fetch-timeout fault for the top level and the bench.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- FETCH_TIMEOUT, 15, cycles FETCH may wait for imem_ack before FAULT (1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; while high, the sequencer executes continuously.
- step  in  1  one-cycle pulse; executes exactly one instruction from IDLE.
- imem_req  out  1  fetch request to program memory.
- imem_addr  out  8  fetch address; equals pc while imem_req is high.
- imem_ack  in  1  memory acknowledge; imem_data is valid in the same cycle.
- imem_data  in  8  fetched opcode.
- instruction  out  8  latched opcode driven to the decode stage.
- current_pc  out  8  registered PC driven to the decode stage.
- next_pc  in  8  PC computed by the decode stage.
- exec_en  out  1  execute strobe; the top level ANDs every register, accumulator, ext and flag write enable with it.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- retired  out  16  count of executed instructions.

Behaviour:
- Clock and reset are decided: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - state = IDLE, pc = RESET_PC, instruction = 8'h00.
  - imem_req = 0, exec_en = 0, halted = 0, fault = 0, retired = 0.
  - Timeout counter = 0, step_mode = 0.
- Reset wins over every other input in every state, including mid-fetch and HALT/FAULT.
- IDLE:
  - If run = 1, go to FETCH with step_mode = 0.
  - Else if step = 1, go to FETCH with step_mode = 1.
  - If run and step are high in the same cycle, run wins.
  - Outputs are inactive.
- FETCH:
  - imem_req = 1 and imem_addr = pc every cycle in this state.
  - On imem_ack = 1: instruction <= imem_data, clear the timeout counter, go to EXEC.
  - Without ack, the timeout counter increments. When it reaches FETCH_TIMEOUT with no ack, go to FAULT.
  - An ack in the same cycle the counter reaches FETCH_TIMEOUT counts as a successful fetch.
- EXEC (exactly 1 cycle):
  - exec_en = 1; pc <= next_pc; retired increments, saturating at 16'hFFFF.
  - If instruction == 8'hFF, go to HALT.
  - Else if run = 1 and step_mode = 0, go to FETCH.
  - Else go to IDLE and clear step_mode.
- HALT:
  - halted = 1, and pc holds the HALT address.
  - Exit only via reset; run and step are ignored.
- FAULT:
  - fault = 1; pc holds the unacknowledged address.
  - Exit only via reset.
- imem_ack outside FETCH is ignored. step outside IDLE is ignored (it is not queued).
- If run drops during FETCH, the fetch and its EXEC still complete, then the sequencer goes to IDLE.
- Throughput: with ack on the first FETCH cycle, one instruction per 2 cycles. Each wait cycle adds 1.
- PC wraps modulo 256, taken as-is from next_pc. No further PC arithmetic happens inside this block.
- exec_en is never high outside EXEC. Decode side effects therefore occur exactly once per fetched opcode, even if ack is delayed.

Test Plan:
- Reset, then run = 1 with memory acking immediately and program 0x10 0x11 0xFF:
  - imem_addr sequence is 0,1,2.
  - exec_en pulses every 2nd cycle.
  - halted = 1 after the 3rd EXEC, with pc = 2 and retired = 3.
- run = 0 with one step pulse on 0x06:
  - Exactly one FETCH and one EXEC occur, then IDLE.
  - retired = 1, pc = 1, and imem_req stays low afterwards.
- Ack delayed by 3 cycles:
  - imem_req and imem_addr are held stable for 4 cycles.
  - exec_en pulses exactly once per instruction.
- No ack for 15 cycles in FETCH at pc = 0x04:
  - fault = 1 and imem_req = 0.
  - pc stays 0x04 until reset.
- Branch with next_pc = 0x0A returned during EXEC:
  - The next imem_addr is 0x0A.
  - With next_pc = 0x00 at pc = 0xFF, the next fetch address wraps to 0x00.
- Reset asserted in the FETCH wait cycle and in HALT:
  - All outputs return to their reset values on the next edge.
  - The next fetch after reset uses imem_addr = RESET_PC.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 8-bit tiny processor: owns the PC, fetches opcodes
// over a req/ack handshake and strobes exec_en for exactly one cycle per fetched opcode.
module instr_sequencer #(
    parameter logic [7:0] RESET_PC      = 8'h00,
    parameter int         FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_data,
    output logic [7:0]  instruction,
    output logic [7:0]  current_pc,
    input  logic [7:0]  next_pc,
    output logic        exec_en,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [7:0] OP_HALT  = 8'hFF;
    // Last wait-counter value that still allows an ack to be accepted.
    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state_reg;
    logic [7:0]  pc_reg;
    logic [7:0]  instr_reg;
    logic [7:0]  tmo_reg;
    logic        step_mode_reg;
    logic [15:0] retired_reg;
    logic        req_reg;
    logic        exec_reg;
    logic        halted_reg;
    logic        fault_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            pc_reg        <= RESET_PC;
            instr_reg     <= 8'h00;
            tmo_reg       <= 8'h00;
            step_mode_reg <= 1'b0;
            retired_reg   <= 16'h0000;
            req_reg       <= 1'b0;
            exec_reg      <= 1'b0;
            halted_reg    <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (run) begin
                        state_reg     <= S_FETCH;
                        step_mode_reg <= 1'b0;
                        req_reg       <= 1'b1;
                    end else if (step) begin
                        state_reg     <= S_FETCH;
                        step_mode_reg <= 1'b1;
                        req_reg       <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_reg <= imem_data;
                        tmo_reg   <= 8'h00;
                        state_reg <= S_EXEC;
                        req_reg   <= 1'b0;
                        exec_reg  <= 1'b1;
                    end else if (tmo_reg == TMO_LAST) begin
                        state_reg <= S_FAULT;
                        req_reg   <= 1'b0;
                        fault_reg <= 1'b1;
                    end else begin
                        tmo_reg <= tmo_reg + 8'h01;
                    end
                end
                S_EXEC: begin
                    exec_reg <= 1'b0;
                    if (retired_reg != 16'hFFFF) begin
                        retired_reg <= retired_reg + 16'h0001;
                    end
                    // HALT keeps its own address in the PC so the bench/top can see where it stopped.
                    if (instr_reg == OP_HALT) begin
                        state_reg  <= S_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        pc_reg <= next_pc;
                        if (run && !step_mode_reg) begin
                            state_reg <= S_FETCH;
                            req_reg   <= 1'b1;
                        end else begin
                            state_reg     <= S_IDLE;
                            step_mode_reg <= 1'b0;
                        end
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                S_FAULT: begin
                    state_reg <= S_FAULT;
                end
                default: begin
                    state_reg <= S_IDLE;
                    req_reg   <= 1'b0;
                    exec_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign instruction = instr_reg;
    assign current_pc  = pc_reg;
    assign exec_en     = exec_reg;
    assign halted      = halted_reg;
    assign fault       = fault_reg;
    assign retired     = retired_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a per-instruction schedule model predicts every
// output cycle by cycle, plus literal end-of-test expectations.
module tb_instr_sequencer;

    localparam int TMO   = 15;
    localparam int NEVER = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [7:0]  imem_data = 8'h00;
    logic [7:0]  instruction;
    logic [7:0]  current_pc;
    logic [7:0]  next_pc;
    logic        exec_en;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    instr_sequencer #(.RESET_PC(8'h00), .FETCH_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .instruction(instruction), .current_pc(current_pc),
        .next_pc(next_pc), .exec_en(exec_en), .halted(halted), .fault(fault),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Program listed in fetch order: opcode, ack wait cycles, next_pc returned by decode.
    logic [7:0] p_op  [32];
    int         p_dly [32];
    logic [7:0] p_npc [32];
    int         fetch_cnt = 0;
    int         wcnt = 0;

    assign next_pc = (fetch_cnt > 0 && fetch_cnt <= 32) ? p_npc[fetch_cnt-1] : 8'h00;

    // Memory responder: acks after the programmed number of wait cycles.
    always @(posedge clk) begin
        if (reset) begin
            fetch_cnt = 0;
            wcnt      = 0;
        end else if (imem_req && imem_ack) begin
            fetch_cnt = fetch_cnt + 1;
            wcnt      = 0;
        end else if (imem_req) begin
            wcnt = wcnt + 1;
        end else begin
            wcnt = 0;
        end
        #1;
        if (fetch_cnt < 32) begin
            imem_ack  = imem_req && (p_dly[fetch_cnt] != NEVER) && (wcnt == p_dly[fetch_cnt]);
            imem_data = p_op[fetch_cnt];
        end else begin
            imem_ack  = 1'b0;
            imem_data = 8'h00;
        end
    end

    typedef struct {
        logic        req;
        logic [7:0]  addr;
        logic        exec;
        logic        halted;
        logic        fault;
        logic [15:0] ret;
        logic [7:0]  pc;
        logic [7:0]  instr;
    } rec_t;

    rec_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         m_pc = 0;
    int         m_ret = 0;
    logic [7:0] m_instr = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic req, input logic exec, input logic hlt, input logic flt);
        rec_t r;
        r.req    = req;
        r.addr   = 8'(m_pc);
        r.exec   = exec;
        r.halted = hlt;
        r.fault  = flt;
        r.ret    = 16'(m_ret);
        r.pc     = 8'(m_pc);
        r.instr  = m_instr;
        return r;
    endfunction

    // Each instruction costs (wait+1) fetch cycles and one exec cycle; a fetch that
    // outlasts TMO cycles ends in fault, opcode FF ends in halt.
    task automatic gen(input bit one_shot);
        for (int k = 0; k < 32; k++) begin
            if (p_dly[k] >= TMO) begin
                for (int i = 0; i < TMO; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
                repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
                return;
            end
            for (int i = 0; i <= p_dly[k]; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
            m_instr = p_op[k];
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
            m_ret = m_ret + 1;
            if (m_instr == 8'hFF) begin
                repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
                return;
            end
            m_pc = int'(p_npc[k]);
            if (one_shot) begin
                repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
                return;
            end
        end
    endtask

    always @(negedge clk) begin : compare
        rec_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("imem_req", 32'(imem_req), 32'(r.req));
            if (r.req) chk("imem_addr", 32'(imem_addr), 32'(r.addr));
            chk("exec_en", 32'(exec_en), 32'(r.exec));
            chk("halted", 32'(halted), 32'(r.halted));
            chk("fault", 32'(fault), 32'(r.fault));
            chk("retired", 32'(retired), 32'(r.ret));
            chk("current_pc", 32'(current_pc), 32'(r.pc));
            chk("instruction", 32'(instruction), 32'(r.instr));
            if (r.exec) $display("txn exec pc=%02h op=%02h retired=%0d", r.pc, r.instr, r.ret);
        end
    end

    task automatic clear_prog();
        for (int k = 0; k < 32; k++) begin
            p_op[k]  = 8'h00;
            p_dly[k] = 0;
            p_npc[k] = 8'(k + 1);
        end
    endtask

    task automatic set_i(input int k, input logic [7:0] op, input int dly, input logic [7:0] npc);
        p_op[k]  = op;
        p_dly[k] = dly;
        p_npc[k] = npc;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_exec"}, 32'(exec_en), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_retired"}, 32'(retired), 32'd0);
        chk({tag, "_pc"}, 32'(current_pc), 32'h00);
        chk({tag, "_instr"}, 32'(instruction), 32'h00);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #2;
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        @(posedge clk); #2;
        chk_reset_vals(tag);
        reset = 1'b0;
        exp_q.delete();
        m_pc    = 0;
        m_ret   = 0;
        m_instr = 8'h00;
        $display("txn reset %s", tag);
    endtask

    task automatic start(input bit use_step, input bit one_shot);
        @(posedge clk); #2;
        if (use_step) step = 1'b1;
        else          run  = 1'b1;
        @(posedge clk); #2;
        step = 1'b0;
        if (one_shot) run = 1'b0;
        gen(one_shot || use_step);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: %0d expected cycles left, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear_prog();
        repeat (2) @(posedge clk);
        do_reset("por");

        // Straight-line run ending in HALT.
        clear_prog();
        set_i(0, 8'h10, 0, 8'h01);
        set_i(1, 8'h11, 0, 8'h02);
        set_i(2, 8'hFF, 0, 8'h02);
        start(1'b0, 1'b0);
        wait_drain("run");
        chk("run_halted", 32'(halted), 32'd1);
        chk("run_pc", 32'(current_pc), 32'h02);
        chk("run_retired", 32'(retired), 32'd3);
        step = 1'b1;
        @(posedge clk); #2;
        step = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("halt_hold_req", 32'(imem_req), 32'd0);
        chk("halt_hold_retired", 32'(retired), 32'd3);
        do_reset("in_halt");

        // Single step.
        clear_prog();
        set_i(0, 8'h06, 0, 8'h01);
        start(1'b1, 1'b1);
        wait_drain("step");
        chk("step_retired", 32'(retired), 32'd1);
        chk("step_pc", 32'(current_pc), 32'h01);
        chk("step_req_low", 32'(imem_req), 32'd0);

        // run dropped mid-fetch: the instruction still completes, then idle.
        do_reset("pre_drop");
        clear_prog();
        set_i(0, 8'h07, 3, 8'h05);
        start(1'b0, 1'b1);
        wait_drain("drop");
        chk("drop_pc", 32'(current_pc), 32'h05);
        chk("drop_retired", 32'(retired), 32'd1);

        // Delayed acks, including an ack on the last permitted fetch cycle.
        do_reset("pre_delay");
        clear_prog();
        set_i(0, 8'h20, 3, 8'h01);
        set_i(1, 8'h21, TMO - 1, 8'h02);
        set_i(2, 8'hFF, 1, 8'h02);
        start(1'b0, 1'b0);
        wait_drain("delay");
        chk("delay_retired", 32'(retired), 32'd3);
        chk("delay_fault", 32'(fault), 32'd0);

        // Branch to 0x0A, then 0xFF, then wrap to 0x00.
        do_reset("pre_branch");
        clear_prog();
        set_i(0, 8'h30, 0, 8'h0A);
        set_i(1, 8'h31, 2, 8'hFF);
        set_i(2, 8'h32, 0, 8'h00);
        set_i(3, 8'hFF, 0, 8'h00);
        start(1'b0, 1'b0);
        wait_drain("branch");
        chk("branch_pc", 32'(current_pc), 32'h00);
        chk("branch_retired", 32'(retired), 32'd4);

        // Fetch timeout at pc 0x04.
        do_reset("pre_fault");
        clear_prog();
        set_i(0, 8'h40, 0, 8'h04);
        set_i(1, 8'h41, NEVER, 8'h00);
        start(1'b0, 1'b0);
        wait_drain("fault");
        chk("fault_flag", 32'(fault), 32'd1);
        chk("fault_req", 32'(imem_req), 32'd0);
        chk("fault_pc", 32'(current_pc), 32'h04);
        step = 1'b1;
        @(posedge clk); #2;
        step = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("fault_hold_pc", 32'(current_pc), 32'h04);
        chk("fault_hold_flag", 32'(fault), 32'd1);

        // Reset during a fetch wait cycle, then a fresh fetch from RESET_PC.
        do_reset("after_fault");
        clear_prog();
        set_i(0, 8'h50, NEVER, 8'h00);
        @(posedge clk); #2;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("wait_req", 32'(imem_req), 32'd1);
        chk("wait_addr", 32'(imem_addr), 32'h00);
        do_reset("mid_fetch");
        clear_prog();
        set_i(0, 8'hFF, 0, 8'h00);
        start(1'b0, 1'b0);
        wait_drain("post_reset");
        chk("post_reset_halted", 32'(halted), 32'd1);
        chk("post_reset_pc", 32'(current_pc), 32'h00);
        chk("post_reset_retired", 32'(retired), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
